// File: rtl/dl_arb_pkg.sv
// Shared types and helpers for the five-requester round-robin arbiter.
//   NUM_REQ      : number of requesters
//   IDX_W        : width of a requester index
//   arb_state_t  : arbiter FSM state (idle / locked mid-packet)
//   rr_next_idx  : round-robin search, returns {found, idx}
package dl_arb_pkg;

  localparam int unsigned NUM_REQ = 5;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  // First set bit of req searching ptr, ptr+1, ... wrapping modulo NUM_REQ.
  // The loop runs from the farthest candidate down to ptr, so the nearest hit
  // is written last and wins.
  function automatic logic [IDX_W:0] rr_next_idx(input logic [IDX_W-1:0]   ptr,
                                                 input logic [NUM_REQ-1:0] req);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] k;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (req[k]) begin
        res = {1'b1, k};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dl_mux5.sv
// Five-input binary-select multiplexer.
//   in0..in4 : candidate inputs, NUM_BITS wide
//   sel      : index of the selected input (0-4); out-of-range selects in0
//   out      : selected input
module dl_mux5 #(
  parameter int unsigned NUM_BITS = 32
) (
  input  logic [NUM_BITS-1:0] in0,
  input  logic [NUM_BITS-1:0] in1,
  input  logic [NUM_BITS-1:0] in2,
  input  logic [NUM_BITS-1:0] in3,
  input  logic [NUM_BITS-1:0] in4,
  input  logic [2:0]          sel,
  output logic [NUM_BITS-1:0] out
);

  always_comb begin
    out = in0;
    case (sel)
      3'd1:    out = in1;
      3'd2:    out = in2;
      3'd3:    out = in3;
      3'd4:    out = in4;
      default: out = in0;
    endcase
  end

endmodule

// File: rtl/dl_arb5_rr.sv
// Five-requester round-robin arbiter with multi-beat packet locking, feeding a
// one-entry output register.
//   clk, rst             : clock, synchronous active-high reset
//   req_val/req_last     : per-requester valid and last-beat flag
//   req_data0..req_data4 : per-requester payload
//   req_rdy              : per-requester ready, one-hot or zero
//   out_val/out_data/out_last/out_src : registered output beat and its source
//   out_rdy              : downstream accept
//   locked               : grant held mid-packet
module dl_arb5_rr
  import dl_arb_pkg::*;
#(
  parameter int unsigned NUM_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req_val,
  input  logic [NUM_REQ-1:0]  req_last,
  input  logic [NUM_BITS-1:0] req_data0,
  input  logic [NUM_BITS-1:0] req_data1,
  input  logic [NUM_BITS-1:0] req_data2,
  input  logic [NUM_BITS-1:0] req_data3,
  input  logic [NUM_BITS-1:0] req_data4,
  output logic [NUM_REQ-1:0]  req_rdy,
  output logic                out_val,
  output logic [NUM_BITS-1:0] out_data,
  output logic                out_last,
  output logic [IDX_W-1:0]    out_src,
  input  logic                out_rdy,
  output logic                locked
);

  arb_state_t       state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] lock_idx_q;

  logic             load_en;
  logic             grant;
  logic [IDX_W-1:0] gidx;
  logic [IDX_W:0]   search;
  logic [NUM_REQ-1:0] gsel;
  logic             xfer;
  logic [NUM_BITS:0] mux_out;

  assign load_en = !out_val || out_rdy;
  assign search  = rr_next_idx(ptr_q, req_val);

  always_comb begin
    grant = 1'b0;
    gidx  = '0;
    if (state_q == ARB_LOCKED) begin
      grant = 1'b1;
      gidx  = lock_idx_q;
    end else begin
      grant = search[IDX_W];
      gidx  = search[IDX_W-1:0];
    end
  end

  always_comb begin
    gsel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant && (gidx == IDX_W'(i))) begin
        gsel[i] = 1'b1;
      end
    end
  end

  // Ready is suppressed during reset so no beat is offered while the lock drops.
  assign req_rdy = (load_en && !rst) ? gsel : '0;
  assign xfer    = |(req_val & req_rdy);

  dl_mux5 #(
    .NUM_BITS(NUM_BITS + 1)
  ) u_mux (
    .in0(  {req_last[0], req_data0}),
    .in1(  {req_last[1], req_data1}),
    .in2(  {req_last[2], req_data2}),
    .in3(  {req_last[3], req_data3}),
    .in4(  {req_last[4], req_data4}),
    .sel(  gidx),
    .out(  mux_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      locked     <= 1'b0;
      ptr_q      <= '0;
      lock_idx_q <= '0;
      out_val    <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_src    <= '0;
    end else begin
      if (xfer) begin
        out_val  <= 1'b1;
        out_data <= mux_out[NUM_BITS-1:0];
        out_last <= mux_out[NUM_BITS];
        out_src  <= gidx;
        if (mux_out[NUM_BITS]) begin
          state_q <= ARB_IDLE;
          locked  <= 1'b0;
          ptr_q   <= (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
        end else begin
          state_q    <= ARB_LOCKED;
          locked     <= 1'b1;
          lock_idx_q <= gidx;
        end
      end else if (load_en) begin
        out_val <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dl_arb5_rr.sv
module tb_dl_arb5_rr;

  logic        clk;
  logic        rst;
  logic [4:0]  req_val;
  logic [4:0]  req_last;
  logic [31:0] req_data [5];
  logic [4:0]  req_rdy;
  logic        out_val;
  logic [31:0] out_data;
  logic        out_last;
  logic [2:0]  out_src;
  logic        out_rdy;
  logic        locked;

  int checks = 0;
  int errors = 0;

  // Reference model: packet-level view of the arbiter.
  int          m_ptr;
  int          m_owner;
  bit          m_in_packet;
  bit          m_oval;
  bit          m_olast;
  logic [31:0] m_odata;
  int          m_osrc;

  dl_arb5_rr #(
    .NUM_BITS(32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_val  (req_val),
    .req_last (req_last),
    .req_data0(req_data[0]),
    .req_data1(req_data[1]),
    .req_data2(req_data[2]),
    .req_data3(req_data[3]),
    .req_data4(req_data[4]),
    .req_rdy  (req_rdy),
    .out_val  (out_val),
    .out_data (out_data),
    .out_last (out_last),
    .out_src  (out_src),
    .out_rdy  (out_rdy),
    .locked   (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Who the channel belongs to this cycle, or -1 if nobody.
  function automatic int model_winner();
    if (m_in_packet) return m_owner;
    for (int j = 0; j < 5; j++) begin
      if (req_val[(m_ptr + j) % 5]) return (m_ptr + j) % 5;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_in_packet = 0;
    m_oval = 0; m_olast = 0; m_odata = '0; m_osrc = 0;
  endtask

  // One clock: drive inputs, check ready, clock, check registered outputs.
  task automatic step(input bit r, input logic [4:0] v, input logic [4:0] l, input bit ordy);
    int   w;
    bit   room;
    logic [4:0] exp_rdy;
    @(negedge clk);
    rst = r; req_val = v; req_last = l; out_rdy = ordy;
    for (int i = 0; i < 5; i++) req_data[i] = $urandom;
    #1;
    w       = model_winner();
    room    = !m_oval || ordy;
    exp_rdy = (!r && room && w >= 0) ? 5'(1 << w) : 5'd0;
    check_eq("req_rdy", 64'(req_rdy), 64'(exp_rdy));
    if (r) begin
      model_reset();
    end else if (room) begin
      if (w >= 0 && v[w]) begin
        m_oval = 1; m_odata = req_data[w]; m_olast = l[w]; m_osrc = w;
        if (l[w]) begin
          m_in_packet = 0;
          m_ptr = (w + 1) % 5;
        end else begin
          m_in_packet = 1;
          m_owner = w;
        end
      end else begin
        m_oval = 0;
      end
    end
    @(posedge clk);
    #1;
    check_eq("out_val",  64'(out_val),  64'(m_oval));
    check_eq("out_data", 64'(out_data), 64'(m_odata));
    check_eq("out_last", 64'(out_last), 64'(m_olast));
    check_eq("out_src",  64'(out_src),  64'(m_osrc));
    check_eq("locked",   64'(locked),   64'(m_in_packet));
  endtask

  initial begin
    int          r;
    logic [4:0]  v;
    logic [4:0]  l;
    model_reset();
    rst = 1'b1; req_val = '0; req_last = '0; out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) req_data[i] = '0;

    // Reset held with every requester valid.
    step(1, 5'b11111, 5'b11111, 1);
    step(1, 5'b11111, 5'b11111, 1);

    // Single-beat packets rotate 0,1,2,3,4,0 back to back.
    for (int i = 0; i < 6; i++) begin
      step(0, 5'b11111, 5'b11111, 1);
      check_eq("rr_order", 64'(out_src), 64'(i % 5));
    end

    // Requester 1 holds a 3-beat packet, then 2, then 0.
    step(0, 5'b00111, 5'b00000, 1);
    check_eq("lock_src1", 64'(out_src), 64'd1);
    step(0, 5'b00111, 5'b00000, 1);
    check_eq("lock_held", 64'(locked), 64'd1);
    step(0, 5'b00111, 5'b00010, 1);
    check_eq("lock_end", 64'(locked), 64'd0);
    step(0, 5'b00111, 5'b00111, 1);
    check_eq("after_lock2", 64'(out_src), 64'd2);
    step(0, 5'b00111, 5'b00111, 1);
    check_eq("after_lock0", 64'(out_src), 64'd0);

    // Backpressure: output must hold for four stalled cycles.
    for (int i = 0; i < 4; i++) step(0, 5'b11111, 5'b11111, 0);
    step(0, 5'b11111, 5'b11111, 1);

    // Pointer wrap: grant 3, then only 0 and 4 valid -> 4 then 0.
    step(0, 5'b01000, 5'b11111, 1);
    step(0, 5'b10001, 5'b11111, 1);
    check_eq("wrap4", 64'(out_src), 64'd4);
    step(0, 5'b10001, 5'b11111, 1);
    check_eq("wrap0", 64'(out_src), 64'd0);

    // Reset mid-packet from requester 2; requester 0 wins afterwards.
    step(0, 5'b00100, 5'b00000, 1);
    step(0, 5'b00100, 5'b00000, 1);
    step(1, 5'b00101, 5'b00000, 1);
    check_eq("rst_mid_lock", 64'(locked), 64'd0);
    step(0, 5'b00101, 5'b11111, 1);
    check_eq("rst_first0", 64'(out_src), 64'd0);

    // Randomised traffic, including stalled owners and occasional reset.
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      v = 5'($urandom);
      l = 5'($urandom) | 5'($urandom);
      step(r == 0, v, l, $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
